// File: rtl/fsm_result_checker.sv
// On-chip scoreboard for the FSM core: checks the out stream's step sequence,
// final value and cycle budget. Define CHK_FIRST_ERR_EN to add first-error capture.
module fsm_result_checker #(
  parameter logic [4:0]  INIT_VAL   = 5'd0,
  parameter logic [4:0]  STEP       = 5'd1,
  parameter logic [4:0]  FINAL_VAL  = 5'd31,
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned CW         = 16
) (
  input  logic          clk_p,
  input  logic          reset,
  input  logic          start,
  input  logic          clr,
  input  logic [4:0]    out_in,
  input  logic          ready_in,
  output logic          done,
  output logic          correct,
  output logic          timeout,
  output logic [7:0]    mismatch_cnt,
  output logic [CW-1:0] cycle_cnt
`ifdef CHK_FIRST_ERR_EN
  ,
  output logic [4:0]    first_err_val,
  output logic [CW-1:0] first_err_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] BUDGET  = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t       state, state_next;
  logic [4:0]   prev_val;
  logic         prev_ready;
  logic         first;

  logic [CW-1:0] cycle_next;
  logic [7:0]    mismatch_next;
  logic [4:0]    step_val;
  logic          step_err;
  logic          ready_edge;
  logic          budget_hit;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step_val      = prev_val + STEP;
    cycle_next    = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CW'(1);
    step_err      = 1'b0;
    if (first)
      step_err = (out_in != INIT_VAL);
    else if (out_in != prev_val)
      step_err = (out_in != step_val);
    mismatch_next = (step_err && mismatch_cnt != 8'hFF) ? mismatch_cnt + 8'd1 : mismatch_cnt;
    ready_edge    = ready_in & ~prev_ready;
    budget_hit    = (cycle_next >= BUDGET);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (ready_edge || budget_hit) state_next = DONE;
      DONE:    if (clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the reset is asynchronous and active-low, so it sits in the
  // sensitivity list and wins over every clocked update.
  always_ff @(posedge clk_p or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_p or negedge reset) begin
    if (!reset) begin
      done          <= 1'b0;
      correct       <= 1'b0;
      timeout       <= 1'b0;
      mismatch_cnt  <= '0;
      cycle_cnt     <= '0;
      prev_val      <= '0;
      prev_ready    <= 1'b0;
      first         <= 1'b1;
`ifdef CHK_FIRST_ERR_EN
      first_err_val <= '0;
      first_err_idx <= '0;
`endif
    end else begin
      // Tracked in every state so a ready level held across RUN entry is not an edge.
      prev_ready <= ready_in;
      case (state)
        IDLE: if (start) begin
          done          <= 1'b0;
          correct       <= 1'b0;
          timeout       <= 1'b0;
          mismatch_cnt  <= '0;
          cycle_cnt     <= '0;
          prev_val      <= '0;
          first         <= 1'b1;
`ifdef CHK_FIRST_ERR_EN
          first_err_val <= '0;
          first_err_idx <= '0;
`endif
        end
        RUN: begin
          cycle_cnt    <= cycle_next;
          mismatch_cnt <= mismatch_next;
          prev_val     <= out_in;
          first        <= 1'b0;
`ifdef CHK_FIRST_ERR_EN
          // mismatch_cnt is zeroed at run start, so zero means no error seen yet.
          if (step_err && mismatch_cnt == 8'd0) begin
            first_err_val <= out_in;
            first_err_idx <= cycle_next;
          end
`endif
          if (ready_edge) begin
            done    <= 1'b1;
            correct <= (mismatch_next == 8'd0) && (out_in == FINAL_VAL) &&
                       (cycle_next <= BUDGET);
          end else if (budget_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: if (clr) begin
          done    <= 1'b0;
          correct <= 1'b0;
          timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fsm_result_checker.md
Name: fsm_result_checker

Overview:
- Downstream consumer of the FSM core `main`. Monitors its 5-bit `out` stream and `ready` flag while a run is in progress.
- Produces the `correct` verdict, cycle count and error statistics that the top-level bench writes to result/cycle files.
- Acts as an on-chip scoreboard: checks step sequence, final value and cycle budget.

Parameters:
- INIT_VAL, 0, expected first sampled value of `out` after `start`.
- STEP, 1, required increment (mod 32) between consecutive distinct `out` values.
- FINAL_VAL, 31, required value of `out` on the cycle `ready` rises.
- MAX_CYCLES, 100, cycle budget; the run fails with timeout if exceeded.
- CW, 16, width of the cycle counter.

Ports:
- clk_p  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  level; launches a run when sampled high in IDLE.
- clr  input  1  synchronous clear from DONE back to IDLE; ignored in other states.
- out_in  input  5  `out` of the FSM core.
- ready_in  input  1  `ready` of the FSM core.
- done  output  1  verdict valid.
- correct  output  1  pass verdict; meaningful only when done=1.
- timeout  output  1  run ended by cycle budget.
- mismatch_cnt  output  8  number of step/initial-value errors, saturating at 255.
- cycle_cnt  output  CW  RUN cycles elapsed, saturating at 2^CW-1.

Behaviour:
- Reset (reset=0, async): state=IDLE; done=0, correct=0, timeout=0, mismatch_cnt=0, cycle_cnt=0; internal prev_val=0, prev_ready=0, first=1.
- IDLE:
  - start=1 → RUN next cycle; counters cleared on that edge; first=1.
  - ready_in and out_in are ignored.
- RUN, every cycle:
  - cycle_cnt += 1 (saturating). The cycle_cnt value includes the current cycle.
  - If first=1: compare out_in with INIT_VAL; a mismatch increments mismatch_cnt. Then set first=0 and prev_val=out_in.
  - Otherwise, if out_in != prev_val: the new value must equal (prev_val+STEP) mod 32, else mismatch_cnt += 1. Then prev_val=out_in.
  - Otherwise (out_in == prev_val): hold, no check.
  - prev_ready is registered every cycle.
- Ready rising edge (ready_in=1, prev_ready=0) in RUN:
  - The step check for that cycle still applies.
  - Next state DONE; done=1.
  - correct = (mismatch_cnt after this cycle's update == 0) AND (out_in == FINAL_VAL) AND (cycle_cnt ≤ MAX_CYCLES).
- ready_in already high on RUN entry: not an edge. The run waits for a fresh rising edge.
- Timeout: cycle_cnt reaches MAX_CYCLES without a ready edge → next state DONE with done=1, timeout=1, correct=0.
- Ready edge and budget exhaustion in the same cycle: the ready edge wins; timeout=0 and the verdict is evaluated normally.
- DONE: all outputs held stable. start is ignored (no auto re-run). clr=1 → IDLE with done=0, correct=0, timeout=0; counters hold their values until the next run starts.
- Reset mid-run: immediate return to IDLE with all outputs cleared.
- Arithmetic: the step check uses 5-bit modulo addition, so 31+1 wraps to 0 and is a legal step.

Optional Feature:
- Macro CHK_FIRST_ERR_EN.
- Defined: adds outputs first_err_val[4:0] and first_err_idx[CW-1:0].
  - On the first mismatch of a run, they capture out_in and cycle_cnt (the value including that cycle).
  - Later mismatches do not overwrite them.
  - Cleared to 0 on reset and at run start.
- Undefined: ports and logic are absent; the core behaviour is otherwise identical.

Test Plan:
- Clean run: reset low 10ns, start=1, out_in = 0,1,2,…,31 one per cycle, ready_in rises with out_in=31 at cycle 32 → done=1, correct=1, mismatch_cnt=0, cycle_cnt=32, timeout=0.
- Step error: same as the clean run, but out_in jumps 4→6 → mismatch_cnt=1, correct=0. With CHK_FIRST_ERR_EN: first_err_val=6, first_err_idx equals the cycle_cnt value on that cycle.
- Timeout: start=1, ready_in never rises → done=1 on the cycle after cycle_cnt=100; timeout=1, correct=0.
- Simultaneous: ready rises with out_in=31 exactly when cycle_cnt=100, with a correct sequence (holds allowed) → correct=1, timeout=0.
- Wrong final value: clean sequence, but ready rises at out_in=30 → correct=0, mismatch_cnt=0.
- Reset mid-run: drive reset=0 at cycle 10 of RUN → all outputs 0 immediately. Release reset with start=1 → a new run begins and cycle_cnt restarts at 1.
